// File: rtl/det_scan_ctrl.sv
// det_scan_ctrl: sequencer wrapped around the combinational subset/superset
// detector. One accepted pattern is swept across a small on-chip weight bank,
// one weight per cycle. The detector flags for each weight land in per-weight
// result masks, which are then offered to the downstream classifier on a
// valid/ready handshake.
module det_scan_ctrl #(
    parameter int WIDTH = 16,
    parameter int NUM_W = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ack,

    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,

    output logic [WIDTH-1:0] det_in,
    output logic [WIDTH-1:0] det_weight,
    input  logic             det_sub,
    input  logic             det_super,
    input  logic             det_anti,
    input  logic             det_eq,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [NUM_W-1:0] res_sub,
    output logic [NUM_W-1:0] res_super,
    output logic [NUM_W-1:0] res_anti,
    output logic [NUM_W-1:0] res_eq,
    output logic             eq_found,
    output logic [IDX_W-1:0] first_eq_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] bank [NUM_W];
    logic [IDX_W-1:0] idx;

    logic             accept;
    logic             wr_take;
    logic             scan_last;

    // The final weight of a sweep is the one at the top of the bank.
    assign scan_last = (idx == IDX_W'(NUM_W - 1));

    // Next-state and handshake decode. Writes and pattern acceptance are only
    // honoured while idle, so a sweep always sees a frozen bank.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        wr_take   = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                wr_take  = wr_en;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (scan_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Weight bank and write acknowledge. A write coinciding with a pattern
    // accept lands on the same edge, so the sweep that follows reads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_W; i++) begin
                bank[i] <= '0;
            end
            wr_ack <= 1'b0;
        end else begin
            wr_ack <= wr_take;
            if (wr_take) begin
                bank[wr_idx] <= wr_data;
            end
        end
    end

    // Pattern register feeding the detector; holds until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_in <= '0;
        end else if (accept) begin
            det_in <= in_data;
        end
    end

    // Sweep index: starts at 0 on accept, wraps back to 0 after the last weight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (accept) begin
            idx <= '0;
        end else if (state == S_SCAN) begin
            idx <= scan_last ? '0 : idx + IDX_W'(1);
        end
    end

    // Result masks: cleared on accept, then bit idx captures the detector
    // flags for the weight currently on det_weight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_sub   <= '0;
            res_super <= '0;
            res_anti  <= '0;
            res_eq    <= '0;
        end else if (accept) begin
            res_sub   <= '0;
            res_super <= '0;
            res_anti  <= '0;
            res_eq    <= '0;
        end else if (state == S_SCAN) begin
            res_sub[idx]   <= det_sub;
            res_super[idx] <= det_super;
            res_anti[idx]  <= det_anti;
            res_eq[idx]    <= det_eq;
        end
    end

    // Weight mux to the detector; parks on entry 0 outside a sweep.
    always_comb begin
        det_weight = bank[0];
        if (state == S_SCAN) begin
            det_weight = bank[idx];
        end
    end

    // Equality summary derived from the stable res_eq mask; the lowest set
    // index wins, so the search runs from the top down.
    always_comb begin
        eq_found     = |res_eq;
        first_eq_idx = '0;
        for (int i = NUM_W - 1; i >= 0; i--) begin
            if (res_eq[i]) begin
                first_eq_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: tb/tb_det_scan_ctrl.sv
// Bench for det_scan_ctrl: behavioural detector, table of patterns with
// hand-derived masks, scoreboard queue, plus write and reset corner cases.
module tb_det_scan_ctrl;

    localparam int WIDTH = 16;
    localparam int NUM_W = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ack;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] det_in;
    logic [WIDTH-1:0] det_weight;
    logic             det_sub, det_super, det_anti, det_eq;
    logic             out_valid;
    logic             out_ready;
    logic [NUM_W-1:0] res_sub, res_super, res_anti, res_eq;
    logic             eq_found;
    logic [IDX_W-1:0] first_eq_idx;

    det_scan_ctrl #(.WIDTH(WIDTH), .NUM_W(NUM_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_ack(wr_ack),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .det_in(det_in), .det_weight(det_weight),
        .det_sub(det_sub), .det_super(det_super), .det_anti(det_anti), .det_eq(det_eq),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_sub(res_sub), .res_super(res_super), .res_anti(res_anti), .res_eq(res_eq),
        .eq_found(eq_found), .first_eq_idx(first_eq_idx)
    );

    // Behavioural detector
    assign det_sub   = ((det_in & ~det_weight) == '0);
    assign det_super = ((det_weight & ~det_in) == '0);
    assign det_anti  = ((det_in & det_weight) == '0);
    assign det_eq    = (det_in == det_weight);

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sub;
        logic [3:0] sup;
        logic [3:0] anti;
        logic [3:0] eq;
        logic       found;
        logic [1:0] first;
    } exp_t;

    typedef struct {
        logic [15:0] pat;
        int          stall;
        int          mode;   // 0 plain, 1 write during scan, 2 write with accept
        exp_t        e;
    } rec_t;

    exp_t exp_q[$];
    rec_t tbl[8];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic write_w(input logic [IDX_W-1:0] i, input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_idx  = i;
        wr_data = d;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        chk("wr_ack_pulse", 32'(wr_ack), 32'd1);
        @(negedge clk);
        chk("wr_ack_drop", 32'(wr_ack), 32'd0);
    endtask

    task automatic run_rec(input rec_t r);
        exp_t e;
        int   lat;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = r.pat;
        out_ready = (r.stall == 0);
        if (r.mode == 2) begin
            wr_en   = 1'b1;
            wr_idx  = 2'd2;
            wr_data = 16'hFFFF;
        end
        exp_q.push_back(r.e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~r.pat;
        wr_en    = 1'b0;
        lat      = 1;
        chk("det_in_latched", 32'(det_in), 32'(r.pat));
        if (r.mode == 2) begin
            chk("wr_ack_concurrent", 32'(wr_ack), 32'd1);
        end
        if (r.mode == 1) begin
            wr_en   = 1'b1;
            wr_idx  = 2'd2;
            wr_data = 16'hFFFF;
        end
        while (!out_valid && lat < 20) begin
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            @(negedge clk);
            lat++;
            wr_en = 1'b0;
            chk("wr_ack_scan", 32'(wr_ack), 32'd0);
        end
        chk("latency", 32'(lat), 32'(NUM_W + 1));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty: actual=out_valid required=queued_entry");
            end else begin
                e = exp_q.pop_front();
                chk("res_sub",      32'(res_sub),      32'(e.sub));
                chk("res_super",    32'(res_super),    32'(e.sup));
                chk("res_anti",     32'(res_anti),     32'(e.anti));
                chk("res_eq",       32'(res_eq),       32'(e.eq));
                chk("eq_found",     32'(eq_found),     32'(e.found));
                chk("first_eq_idx", 32'(first_eq_idx), 32'(e.first));
                for (int s = 1; s < r.stall; s++) begin
                    @(negedge clk);
                    chk("hold_valid",    32'(out_valid),    32'd1);
                    chk("hold_in_ready", 32'(in_ready),     32'd0);
                    chk("hold_sub",      32'(res_sub),      32'(e.sub));
                    chk("hold_anti",     32'(res_anti),     32'(e.anti));
                    chk("hold_found",    32'(eq_found),     32'(e.found));
                    chk("hold_first",    32'(first_eq_idx), 32'(e.first));
                end
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_back",  32'(in_ready),  32'd1);
        chk("det_in_hold",    32'(det_in),    32'(r.pat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen;
        rec_t z;

        // Bank {FFFF, FF0F, F000, 0FFF}; masks written MSB = weight 3.
        tbl[0] = '{16'h0FFF, 0, 0, '{4'b1001, 4'b1000, 4'b0100, 4'b1000, 1'b1, 2'd3}};
        tbl[1] = '{16'hFFFF, 0, 0, '{4'b0001, 4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0}};
        tbl[2] = '{16'h000F, 5, 0, '{4'b1011, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0}};
        tbl[3] = '{16'hFF0F, 2, 0, '{4'b0011, 4'b0110, 4'b0000, 4'b0010, 1'b1, 2'd1}};
        tbl[4] = '{16'h0000, 0, 0, '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0}};
        tbl[5] = '{16'hF000, 0, 0, '{4'b0111, 4'b0100, 4'b1000, 4'b0100, 1'b1, 2'd2}};
        tbl[6] = '{16'h0FFF, 0, 1, '{4'b1001, 4'b1000, 4'b0100, 4'b1000, 1'b1, 2'd3}};
        // weight 2 becomes FFFF together with this accept
        tbl[7] = '{16'h0FFF, 0, 2, '{4'b1101, 4'b1000, 4'b0000, 4'b1000, 1'b1, 2'd3}};
        // after reset the bank is all zero
        z      = '{16'h0000, 0, 0, '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b1, 2'd0}};

        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_data   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid",  32'(out_valid),    32'd0);
        chk("rst_wr_ack",     32'(wr_ack),       32'd0);
        chk("rst_det_in",     32'(det_in),       32'd0);
        chk("rst_det_weight", 32'(det_weight),   32'd0);
        chk("rst_res_sub",    32'(res_sub),      32'd0);
        chk("rst_res_eq",     32'(res_eq),       32'd0);
        chk("rst_eq_found",   32'(eq_found),     32'd0);
        chk("rst_first_idx",  32'(first_eq_idx), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",   32'(in_ready),     32'd1);

        write_w(2'd0, 16'hFFFF);
        write_w(2'd1, 16'hFF0F);
        write_w(2'd2, 16'hF000);
        write_w(2'd3, 16'h0FFF);
        chk("idle_det_weight", 32'(det_weight), 32'h0000FFFF);

        for (int i = 0; i < 8; i++) begin
            run_rec(tbl[i]);
        end

        // Abort a sweep with reset at scan cycle 2
        in_valid  = 1'b1;
        in_data   = 16'h0FFF;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid",  32'(out_valid),  32'd0);
        chk("abort_in_ready",   32'(in_ready),   32'd1);
        chk("abort_det_weight", 32'(det_weight), 32'd0);
        chk("abort_det_in",     32'(det_in),     32'd0);
        chk("abort_res_anti",   32'(res_anti),   32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("abort_no_result",  32'(seen),       32'd0);
        chk("abort_idle_ready", 32'(in_ready),   32'd1);
        chk("abort_bank0",      32'(det_weight), 32'd0);
        run_rec(z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
